// File: rtl/mem_access_unit.sv
// Load/store stage: passes ALU results to writeback, runs single-beat bus transactions for loads and stores.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_unit #(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       addr_lo;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic [4:0]       rd_q;

  logic        accept, is_mem, misaligned;
  logic        st_done, ld_done, timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  assign in_ready = (state == IDLE);
  assign bus_req  = (state == REQ);
  assign is_mem   = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((mem_size == 2'b01) && alu_result[0]) ||
                      ((mem_size == 2'b10) && (alu_result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Halves always use the addr[1] lane so an odd address never spills past byte 3.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data;
    case (mem_size)
      2'b00: begin
        be_calc    = 4'b0001 << alu_result[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = bus_rdata[7:0];
    case (addr_lo)
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      2'd3:    lane_b = bus_rdata[31:24];
      default: ;
    endcase
    lane_h = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_data = unsigned_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data = bus_rdata;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    st_done    = 1'b0;
    ld_done    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept = 1'b1;
        if (is_mem && !misaligned) state_next = REQ;
      end
      REQ: if (bus_gnt) begin
        if (bus_we) begin
          st_done    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      RESP: if (bus_rvalid) begin
        ld_done    = 1'b1;
        state_next = IDLE;
      end else if (cnt == CNT_LAST) begin
        timeout    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      addr_lo    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      rd_q       <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      exc_valid  <= 1'b0;
      exc_code   <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      exc_code  <= 2'b00;
      cnt       <= (state == RESP) ? cnt + 1'b1 : '0;

      if (accept) begin
        if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_rd    <= rd;
          wb_data  <= alu_result;
        end else if (misaligned) begin
          exc_valid <= 1'b1;
          exc_code  <= mem_read ? 2'b01 : 2'b10;
        end else begin
          // A load wins when both mem_read and mem_write are set.
          bus_we     <= ~mem_read;
          bus_addr   <= {alu_result[31:2], 2'b00};
          bus_be     <= be_calc;
          bus_wdata  <= wdata_calc;
          addr_lo    <= alu_result[1:0];
          size_q     <= mem_size;
          unsigned_q <= mem_unsigned;
          rd_q       <= rd;
        end
      end

      if (st_done) begin
        wb_valid <= 1'b1;
        wb_rd    <= 5'd0;
        wb_data  <= '0;
      end

      if (ld_done) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= load_data;
      end

      if (timeout) begin
        exc_valid <= 1'b1;
        exc_code  <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with RESP_TIMEOUT=4; expected values are hand-computed.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  exc_code;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] dst,
                       input logic rd_en, input logic wr_en, input logic [1:0] size, input logic uns);
    in_valid     = 1'b1;
    alu_result   = addr;
    store_data   = sdata;
    rd           = dst;
    mem_read     = rd_en;
    mem_write    = wr_en;
    mem_size     = size;
    mem_unsigned = uns;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; rd = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_bus_req",  32'(bus_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_exc",      32'(exc_valid), 32'd0);
    chk("rst_bus_be",   32'(bus_be), 32'd0);
    rst_n = 1'b1;
    tick();

    // Non-memory op: latency 1 writeback.
    issue(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 2'b10, 1'b0);
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_rd",    32'(wb_rd), 32'd5);
    chk("alu_wb_data",  wb_data, 32'h0000_1234);
    chk("alu_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("alu_wb_pulse", 32'(wb_valid), 32'd0);

    // Signed byte load at 0x103, grant after 2 cycles.
    issue(32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("lb_bus_req",  32'(bus_req), 32'd1);
    chk("lb_bus_addr", bus_addr, 32'h0000_0100);
    chk("lb_bus_be",   32'(bus_be), 32'b1000);
    chk("lb_bus_we",   32'(bus_we), 32'd0);
    chk("lb_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lb_hold_req",  32'(bus_req), 32'd1);
    chk("lb_hold_addr", bus_addr, 32'h0000_0100);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("lb_resp_req", 32'(bus_req), 32'd0);
    chk("lb_resp_wb",  32'(wb_valid), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h80FF_FFFF;
    tick();
    chk("lb_wb_valid", 32'(wb_valid), 32'd1);
    chk("lb_wb_rd",    32'(wb_rd), 32'd7);
    chk("lb_wb_data",  wb_data, 32'hFFFF_FF80);
    chk("lb_exc",      32'(exc_valid), 32'd0);
    // rvalid held high in IDLE must be ignored.
    tick();
    bus_rvalid = 1'b0;
    chk("idle_rvalid_ignored", 32'(wb_valid), 32'd0);

    // Unsigned half load at 0x202 with both read and write set, zero-wait grant.
    issue(32'h0000_0202, 32'h0, 5'd9, 1'b1, 1'b1, 2'b01, 1'b1);
    bus_gnt = 1'b1;
    chk("lhu_bus_be", 32'(bus_be), 32'b1100);
    chk("lhu_bus_we", 32'(bus_we), 32'd0);
    tick();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h8765_4321;
    tick();
    bus_rvalid = 1'b0;
    chk("lhu_wb_rd",   32'(wb_rd), 32'd9);
    chk("lhu_wb_data", wb_data, 32'h0000_8765);

    // Half store of 0xABCD at 0x202.
    issue(32'h0000_0202, 32'h0000_ABCD, 5'd3, 1'b0, 1'b1, 2'b01, 1'b0);
    chk("sh_bus_req",   32'(bus_req), 32'd1);
    chk("sh_bus_be",    32'(bus_be), 32'b1100);
    chk("sh_bus_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh_bus_we",    32'(bus_we), 32'd1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);
    chk("sh_wb_rd",    32'(wb_rd), 32'd0);
    chk("sh_bus_req_off", 32'(bus_req), 32'd0);

    // Byte store of 0x5A at 0x001.
    issue(32'h0000_0001, 32'h1234_565A, 5'd2, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("sb_bus_be",    32'(bus_be), 32'b0010);
    chk("sb_bus_wdata", bus_wdata, 32'h5A5A_5A5A);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("sb_wb_valid", 32'(wb_valid), 32'd1);

    // Load timeout: grant, then 4 RESP cycles without rvalid.
    issue(32'h0000_0300, 32'h0, 5'd6, 1'b1, 1'b0, 2'b10, 1'b0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();
    tick();
    tick();
    chk("to_cycle4_exc",   32'(exc_valid), 32'd0);
    chk("to_cycle4_ready", 32'(in_ready), 32'd0);
    tick();
    chk("to_exc_valid", 32'(exc_valid), 32'd1);
    chk("to_exc_code",  32'(exc_code), 32'b11);
    chk("to_wb_valid",  32'(wb_valid), 32'd0);
    tick();
    chk("to_exc_pulse", 32'(exc_valid), 32'd0);
    chk("to_in_ready",  32'(in_ready), 32'd1);

    // Word load at 0x001.
    issue(32'h0000_0001, 32'h0, 5'd4, 1'b1, 1'b0, 2'b10, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_bus_req",   32'(bus_req), 32'd0);
    chk("mis_exc_valid", 32'(exc_valid), 32'd1);
    chk("mis_exc_code",  32'(exc_code), 32'b01);
    chk("mis_in_ready",  32'(in_ready), 32'd1);
`else
    chk("mis_bus_req",  32'(bus_req), 32'd1);
    chk("mis_bus_addr", bus_addr, 32'h0000_0000);
    chk("mis_bus_be",   32'(bus_be), 32'b1111);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_rvalid = 1'b0;
    chk("mis_wb_data", wb_data, 32'hDEAD_BEEF);
`endif
    tick();

    // Reset while in RESP, then a stray rvalid.
    issue(32'h0000_0400, 32'h0, 5'd8, 1'b1, 1'b0, 2'b10, 1'b0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("rr_in_resp", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_in_ready", 32'(in_ready), 32'd1);
    chk("rr_bus_req",  32'(bus_req), 32'd0);
    chk("rr_bus_addr", bus_addr, 32'h0);
    chk("rr_wb_data",  wb_data, 32'h0);
    chk("rr_wb_rd",    32'(wb_rd), 32'd0);
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    tick();
    chk("rr_no_wb_1", 32'(wb_valid), 32'd0);
    tick();
    bus_rvalid = 1'b0;
    chk("rr_no_wb_2", 32'(wb_valid), 32'd0);
    chk("rr_wb_data_zero", wb_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
